wfg_wishbone_master: RTL and testbench
======================================

# wfg_wishbone_master

Wishbone classic initiator that turns a simple command/response handshake into single read or write bus cycles. It is the other end of the per-block Wishbone register slaves in the waveform generator, including the `wfg_drive_spi` register file. It lets an on-chip sequencer or test controller program and read back block registers without a CPU. One transaction is in flight at a time; an optional timeout covers a missing acknowledge.

## Interface
Parameters:
- BUSW, 32, address and data width; byte selects are BUSW/8.
- TIMEOUT, 255, number of BUS-state cycles without acknowledge before the cycle is aborted; must be at least 1. Used only with the timeout feature.

Ports:
- wb_clk_i  in  1  single clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  command accepted when valid and ready are both high.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_adr_i  in  BUSW  target address.
- cmd_dat_i  in  BUSW  write data.
- cmd_sel_i  in  BUSW/8  byte selects.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  response consumed when valid and ready are both high.
- rsp_dat_o  out  BUSW  read data; 0 for writes and for errors.
- rsp_err_o  out  1  cycle aborted by timeout.
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1  Wishbone cycle, strobe and write enable.
- wbm_sel_o  out  BUSW/8  Wishbone byte selects.
- wbm_adr_o, wbm_dat_o  out  BUSW  Wishbone address and write data.
- wbm_ack_i  in  1  Wishbone acknowledge.
- wbm_dat_i  in  BUSW  Wishbone read data.

## Operation
- State machine states: IDLE, BUS, RESP.
- IDLE:
  - cmd_ready_o = 1.
  - On accept, latch we/adr/dat/sel into the wbm_* output registers, then go to BUS.
- BUS:
  - wbm_cyc_o = wbm_stb_o = 1; address, data, we and sel are held stable.
  - On wbm_ack_i = 1: capture wbm_dat_i into rsp_dat_o (reads only; writes give 0), set rsp_err_o = 0, go to RESP.
- RESP:
  - rsp_valid_o = 1; rsp_dat_o and rsp_err_o are held.
  - On rsp_ready_i = 1, go to IDLE.
- wbm_ack_i is sampled only in BUS. Slaves keep ack high for one extra cycle after strobe drops; this stale ack, seen in RESP or IDLE, is ignored.
- cmd_ready_o = 0 in BUS and RESP. A command arriving in those states waits; there is no queue.
- Every bus output is registered. cmd_ready_o and rsp_valid_o are decoded directly from state.
- Reset values:
  - State is IDLE.
  - wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o are 0.
  - rsp_valid_o, rsp_dat_o, rsp_err_o are 0.
  - cmd_ready_o is 0 while wb_rst_i = 1.
- Reset mid-operation: at the next edge cyc/stb drop and state returns to IDLE. Any pending response is discarded and is not replayed.

## Timing
- Command accepted at edge k: wbm_cyc_o/wbm_stb_o are high from k+1.
- Slave with registered ack (ack at k+2): rsp_valid_o is high from k+3 and cyc/stb are low from k+3.
  - Minimum command-to-response latency is 3 cycles.
  - Bus occupancy is 2 cycles.
- Response consumed at edge r: cmd_ready_o is high from r+1.
  - Back-to-back throughput is one transaction per 4 cycles when rsp_ready_i is held at 1.
- A combinational (same-cycle) ack gives a 1-cycle BUS state.

## Configuration
- Macro: `WFG_WISHBONE_MASTER_TIMEOUT_EN`.
- Defined:
  - An 8- to 32-bit counter, sized with $clog2(TIMEOUT+1), clears on entry to BUS and increments each BUS cycle without ack.
  - When the count reaches TIMEOUT with no ack that cycle: drop cyc/stb, go to RESP with rsp_err_o = 1 and rsp_dat_o = 0.
  - If ack and the timeout occur in the same cycle, ack wins and rsp_err_o = 0.
- Not defined: no counter exists, BUS waits for ack indefinitely, and rsp_err_o is tied to 0.

## Test plan
- Reset, then write adr 0x8, dat 0x000000A5, sel 0xF to the SPI register slave -> cyc/stb high for 2 cycles, clkcfg_div_q_o = 0xA5, response with rsp_dat_o = 0 and rsp_err_o = 0.
- Read adr 0x4 straight after reset -> rsp_dat_o = 0x00000004 (MSTR reset value 1), no second response from the stale ack.
- Hold rsp_ready_i = 0 for 10 cycles with cmd_valid_i = 1 -> rsp_valid_o and rsp_dat_o stable, cmd_ready_o = 0, no new bus cycle; release -> next cycle starts 1 cycle after the response handshake.
- With TIMEOUT_EN and TIMEOUT = 4, wbm_ack_i tied to 0 -> cyc/stb high for exactly 4 cycles, then response with rsp_err_o = 1 and rsp_dat_o = 0; with ack asserted in the 4th cycle, rsp_err_o = 0.
- Assert wb_rst_i while in BUS -> cyc/stb low at the next edge, rsp_valid_o never rises, and after reset a read of 0x8 returns 0.
- Random back-to-back write/read mix of 200 transactions against the slave model -> every read matches a scoreboard and each response carries the correct data.

Source files
------------

// File: rtl/wfg_wishbone_master.sv
// wfg_wishbone_master: Wishbone classic initiator for single read/write cycles.
// A command handshake starts one bus cycle. A response handshake returns its
// result. Only one transaction is in flight at a time.
// Optional feature macro: WFG_WISHBONE_MASTER_TIMEOUT_EN. When it is defined,
// a BUS cycle with no acknowledge is aborted after TIMEOUT cycles and the
// response carries rsp_err_o = 1.

module wfg_wishbone_master #(
  parameter int BUSW    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  // command channel
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [BUSW-1:0]   cmd_adr_i,
  input  logic [BUSW-1:0]   cmd_dat_i,
  input  logic [BUSW/8-1:0] cmd_sel_i,
  // response channel
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [BUSW-1:0]   rsp_dat_o,
  output logic              rsp_err_o,
  // Wishbone master port
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [BUSW/8-1:0] wbm_sel_o,
  output logic [BUSW-1:0]   wbm_adr_o,
  output logic [BUSW-1:0]   wbm_dat_o,
  input  logic              wbm_ack_i,
  input  logic [BUSW-1:0]   wbm_dat_i
);

  localparam int SELW = BUSW / 8;

  // A zero timeout would abort every cycle before a slave could answer.
  if (TIMEOUT < 1) begin : g_timeout_check
    $error("wfg_wishbone_master: TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            r_cyc;
  logic            w_cyc_next;
  logic            r_we;
  logic            w_we_next;
  logic [SELW-1:0] r_sel;
  logic [SELW-1:0] w_sel_next;
  logic [BUSW-1:0] r_adr;
  logic [BUSW-1:0] w_adr_next;
  logic [BUSW-1:0] r_dat;
  logic [BUSW-1:0] w_dat_next;
  logic [BUSW-1:0] r_rsp_dat;
  logic [BUSW-1:0] w_rsp_dat_next;

`ifdef WFG_WISHBONE_MASTER_TIMEOUT_EN
  // Counter width follows TIMEOUT but stays within 8..32 bits.
  localparam int CNTW_RAW = $clog2(TIMEOUT + 1);
  localparam int CNTW     = (CNTW_RAW < 8) ? 8 : ((CNTW_RAW > 32) ? 32 : CNTW_RAW);

  logic [CNTW-1:0] r_cnt;
  logic [CNTW-1:0] w_cnt_next;
  logic            r_rsp_err;
  logic            w_rsp_err_next;
`endif

  // Next-state and next-register values; ack is only looked at in BUS so a
  // slave's lingering ack in RESP/IDLE has no effect.
  always_comb begin
    w_state_next   = r_state;
    w_cyc_next     = r_cyc;
    w_we_next      = r_we;
    w_sel_next     = r_sel;
    w_adr_next     = r_adr;
    w_dat_next     = r_dat;
    w_rsp_dat_next = r_rsp_dat;
`ifdef WFG_WISHBONE_MASTER_TIMEOUT_EN
    w_cnt_next     = r_cnt;
    w_rsp_err_next = r_rsp_err;
`endif
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid_i && cmd_ready_o) begin
          w_we_next    = cmd_we_i;
          w_adr_next   = cmd_adr_i;
          w_dat_next   = cmd_dat_i;
          w_sel_next   = cmd_sel_i;
          w_cyc_next   = 1'b1;
          w_state_next = ST_BUS;
`ifdef WFG_WISHBONE_MASTER_TIMEOUT_EN
          w_cnt_next   = '0;
`endif
        end
      end
      ST_BUS: begin
        if (wbm_ack_i) begin
          // Ack wins over a timeout that expires in the same cycle.
          w_cyc_next     = 1'b0;
          w_rsp_dat_next = r_we ? '0 : wbm_dat_i;
          w_state_next   = ST_RESP;
`ifdef WFG_WISHBONE_MASTER_TIMEOUT_EN
          w_rsp_err_next = 1'b0;
`endif
        end
`ifdef WFG_WISHBONE_MASTER_TIMEOUT_EN
        else if (r_cnt == CNTW'(TIMEOUT - 1)) begin
          // This is the TIMEOUT-th BUS cycle without ack: abort the cycle.
          w_cyc_next     = 1'b0;
          w_rsp_dat_next = '0;
          w_rsp_err_next = 1'b1;
          w_state_next   = ST_RESP;
        end else begin
          w_cnt_next = r_cnt + CNTW'(1);
        end
`endif
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cyc_next   = 1'b0;
      end
    endcase
  end

  // State and registered bus/response outputs with synchronous reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state   <= ST_IDLE;
      r_cyc     <= 1'b0;
      r_we      <= 1'b0;
      r_sel     <= '0;
      r_adr     <= '0;
      r_dat     <= '0;
      r_rsp_dat <= '0;
`ifdef WFG_WISHBONE_MASTER_TIMEOUT_EN
      r_cnt     <= '0;
      r_rsp_err <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_next;
      r_cyc     <= w_cyc_next;
      r_we      <= w_we_next;
      r_sel     <= w_sel_next;
      r_adr     <= w_adr_next;
      r_dat     <= w_dat_next;
      r_rsp_dat <= w_rsp_dat_next;
`ifdef WFG_WISHBONE_MASTER_TIMEOUT_EN
      r_cnt     <= w_cnt_next;
      r_rsp_err <= w_rsp_err_next;
`endif
    end
  end

  // Handshake flags come straight from state; ready is masked during reset.
  assign cmd_ready_o = (r_state == ST_IDLE) && !wb_rst_i;
  assign rsp_valid_o = (r_state == ST_RESP);
  assign rsp_dat_o   = r_rsp_dat;
`ifdef WFG_WISHBONE_MASTER_TIMEOUT_EN
  assign rsp_err_o   = r_rsp_err;
`else
  assign rsp_err_o   = 1'b0;
`endif

  assign wbm_cyc_o = r_cyc;
  assign wbm_stb_o = r_cyc;
  assign wbm_we_o  = r_we;
  assign wbm_sel_o = r_sel;
  assign wbm_adr_o = r_adr;
  assign wbm_dat_o = r_dat;

endmodule

// File: tb/tb_wfg_wishbone_master.sv
// Directed bench for wfg_wishbone_master with a small four-register slave.
// Slave modes: 0 = registered ack held one extra cycle, 1 = same-cycle ack,
// 2 = never acks, 3 = same-cycle ack in the 4th strobe cycle.

module tb_wfg_wishbone_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat, s_dat;
  logic        s_ack;

  int n_vec = 0;
  int n_err = 0;
  int s_mode = 0;
  int cyc_cnt = 0;

  // last bus attributes seen in the first BUS cycle of a transaction
  logic [31:0] last_adr, last_dat;
  logic [3:0]  last_sel;
  logic        last_we, last_stb;

  always #5 clk = ~clk;

  wfg_wishbone_master #(.BUSW(32), .TIMEOUT(4)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
    .rsp_err_o(rsp_err),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
    .wbm_adr_o(adr), .wbm_dat_o(wdat), .wbm_ack_i(s_ack), .wbm_dat_i(s_dat)
  );

  // ---------------- slave model ----------------
  logic [31:0] s_regs [4];
  logic        s_rack, s_rack_d;
  logic [31:0] s_rdat;
  int          s_cnt;
  logic        s_take;
  logic [1:0]  s_idx;

  assign s_idx = adr[3:2];

  always_comb begin
    s_take = 1'b0;
    s_ack  = 1'b0;
    s_dat  = s_regs[s_idx];
    case (s_mode)
      0: begin
        s_take = cyc && stb && !s_rack && !s_rack_d;
        s_ack  = s_rack || s_rack_d;
        s_dat  = s_rdat;
      end
      1: begin
        s_take = cyc && stb;
        s_ack  = s_take;
      end
      3: begin
        s_take = cyc && stb && (s_cnt == 3);
        s_ack  = s_take;
      end
      default: begin
        s_take = 1'b0;
        s_ack  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (rst) begin
      s_regs[0] <= 32'h0;
      s_regs[1] <= 32'h4;
      s_regs[2] <= 32'h0;
      s_regs[3] <= 32'h0;
      s_rack    <= 1'b0;
      s_rack_d  <= 1'b0;
      s_rdat    <= 32'h0;
      s_cnt     <= 0;
    end else begin
      s_rack   <= (s_mode == 0) && s_take;
      s_rack_d <= s_rack;
      s_cnt    <= (cyc && stb && !s_ack) ? s_cnt + 1 : 0;
      if (s_take) s_rdat <= s_regs[s_idx];
      if (s_take && we) begin
        for (int b = 0; b < 4; b++)
          if (sel[b]) s_regs[s_idx][8*b +: 8] <= wdat[8*b +: 8];
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transaction with rsp_ready held high; returns data, error, BUS cycles.
  task automatic do_txn(input logic t_we, input logic [31:0] t_adr, input logic [31:0] t_dat,
                        input logic [3:0] t_sel, output logic [31:0] rdat,
                        output logic err, output int bus);
    int guard;
    cmd_we = t_we; cmd_adr = t_adr; cmd_dat = t_dat; cmd_sel = t_sel; cmd_valid = 1'b1;
    guard = 0;
    while (!cmd_ready && guard < 50) begin tick(); guard++; end
    if (!cmd_ready) check("cmd_ready_wait", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    last_adr = adr; last_dat = wdat; last_sel = sel; last_we = we; last_stb = stb;
    bus = 0; guard = 0;
    while (cyc && guard < 50) begin bus++; tick(); guard++; end
    if (cyc) check("bus_wait", cyc, 0);
    check("rsp_valid", rsp_valid, 1);
    rdat = rsp_dat;
    err  = rsp_err;
    tick();
  endtask

  logic [31:0] rd;
  logic        er;
  int          bus, t0, guard;
  logic [31:0] sb [4];
  logic        r_we;
  logic [1:0]  r_idx;
  logic [31:0] r_dat;
  logic [3:0]  r_sel;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
    cmd_sel = '0; rsp_ready = 1'b1;
    tick(); tick(); tick();
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_cyc", cyc, 0);
    check("rst_stb", stb, 0);
    check("rst_adr", adr, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_dat", rsp_dat, 0);
    check("rst_rsp_err", rsp_err, 0);
    rst = 1'b0;
    tick();
    check("idle_cmd_ready", cmd_ready, 1);

    // read MSTR straight after reset
    do_txn(1'b0, 32'h4, 32'h0, 4'hF, rd, er, bus);
    check("rd4_dat", rd, 32'h4);
    check("rd4_err", er, 0);
    check("rd4_bus", bus, 2);
    check("rd4_stb", last_stb, 1);
    check("rd4_no_rsp2", rsp_valid, 0);
    check("rd4_ready_back", cmd_ready, 1);
    tick();
    check("rd4_no_rsp3", rsp_valid, 0);
    check("rd4_no_cyc", cyc, 0);

    // write clock-divider register
    do_txn(1'b1, 32'h8, 32'h000000A5, 4'hF, rd, er, bus);
    check("wr8_dat", rd, 0);
    check("wr8_err", er, 0);
    check("wr8_bus", bus, 2);
    check("wr8_adr", last_adr, 32'h8);
    check("wr8_wdat", last_dat, 32'hA5);
    check("wr8_sel", last_sel, 4'hF);
    check("wr8_we", last_we, 1);
    check("wr8_slave", s_regs[2], 32'hA5);
    do_txn(1'b0, 32'h8, 32'h0, 4'hF, rd, er, bus);
    check("rd8_dat", rd, 32'hA5);

    // partial byte select
    do_txn(1'b1, 32'h8, 32'h11223344, 4'h2, rd, er, bus);
    do_txn(1'b0, 32'h8, 32'h0, 4'hF, rd, er, bus);
    check("rd8_bytesel", rd, 32'h000033A5);

    // response back-pressure with a waiting command
    do_txn(1'b1, 32'hC, 32'hDEADBEEF, 4'hF, rd, er, bus);
    rsp_ready = 1'b0;
    cmd_we = 1'b0; cmd_adr = 32'hC; cmd_sel = 4'hF; cmd_valid = 1'b1;
    tick();
    guard = 0;
    while (!rsp_valid && guard < 50) begin tick(); guard++; end
    for (int i = 0; i < 10; i++) begin
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_dat", rsp_dat, 32'hDEADBEEF);
      check("bp_cmd_ready", cmd_ready, 0);
      check("bp_cyc", cyc, 0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    check("bp_release_ready", cmd_ready, 1);
    check("bp_release_cyc", cyc, 0);
    check("bp_release_valid", rsp_valid, 0);
    tick();
    check("bp_next_cyc", cyc, 1);
    cmd_valid = 1'b0;
    guard = 0;
    while (!rsp_valid && guard < 50) begin tick(); guard++; end
    check("bp_next_dat", rsp_dat, 32'hDEADBEEF);
    tick();

    // same-cycle ack gives a one-cycle BUS state
    s_mode = 1;
    do_txn(1'b0, 32'h4, 32'h0, 4'hF, rd, er, bus);
    check("comb_bus", bus, 1);
    check("comb_dat", rd, 32'h4);
    do_txn(1'b1, 32'h0, 32'h12345678, 4'hF, rd, er, bus);
    check("comb_wr_bus", bus, 1);
    s_mode = 0;
    do_txn(1'b0, 32'h0, 32'h0, 4'hF, rd, er, bus);
    check("comb_rd_back", rd, 32'h12345678);

`ifdef WFG_WISHBONE_MASTER_TIMEOUT_EN
    s_mode = 2;
    do_txn(1'b0, 32'h4, 32'h0, 4'hF, rd, er, bus);
    check("to_bus", bus, 4);
    check("to_err", er, 1);
    check("to_dat", rd, 0);
    s_mode = 3;
    do_txn(1'b0, 32'h4, 32'h0, 4'hF, rd, er, bus);
    check("to_ack_bus", bus, 4);
    check("to_ack_err", er, 0);
    check("to_ack_dat", rd, 32'h4);
    s_mode = 0;
`endif

    // reset while in BUS
    cmd_we = 1'b1; cmd_adr = 32'h8; cmd_dat = 32'h5A; cmd_sel = 4'hF; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("rb_cyc_before", cyc, 1);
    rst = 1'b1;
    tick();
    check("rb_cyc", cyc, 0);
    check("rb_stb", stb, 0);
    check("rb_rsp_valid", rsp_valid, 0);
    check("rb_cmd_ready", cmd_ready, 0);
    tick();
    rst = 1'b0;
    check("rb_rsp_valid2", rsp_valid, 0);
    tick();
    check("rb_rsp_valid3", rsp_valid, 0);
    check("rb_cmd_ready2", cmd_ready, 1);
    do_txn(1'b0, 32'h8, 32'h0, 4'hF, rd, er, bus);
    check("rb_rd8", rd, 0);

    // back-to-back throughput
    t0 = cyc_cnt;
    do_txn(1'b0, 32'h4, 32'h0, 4'hF, rd, er, bus);
    check("tput_cycles", cyc_cnt - t0, 4);

    // random mix against scoreboard
    sb[0] = 32'h0; sb[1] = 32'h4; sb[2] = 32'h0; sb[3] = 32'h0;
    for (int n = 0; n < 200; n++) begin
      r_we  = 1'($urandom_range(0, 1));
      r_idx = 2'($urandom_range(0, 3));
      r_dat = $urandom;
      r_sel = 4'($urandom_range(1, 15));
      do_txn(r_we, {28'h0, r_idx, 2'b00}, r_dat, r_sel, rd, er, bus);
      if (r_we) begin
        for (int b = 0; b < 4; b++)
          if (r_sel[b]) sb[r_idx][8*b +: 8] = r_dat[8*b +: 8];
        check("rnd_wr_dat", rd, 0);
      end else begin
        check("rnd_rd_dat", rd, sb[r_idx]);
      end
      check("rnd_err", er, 0);
      check("rnd_bus", bus, 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
